// File: rtl/video_timing_recover.sv
// video_timing_recover: recovers xpos/ypos from an hsync/vsync/data_en stream,
// measures line/frame geometry and locks once that geometry repeats.
module video_timing_recover #(
    parameter int   LOCK_FRAMES = 2,
    parameter logic HSYNC_POL   = 1'b1,
    parameter logic VSYNC_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        data_en,
    output logic        pix_valid,
    output logic [15:0] xpos,
    output logic [15:0] ypos,
    output logic        frame_start,
    output logic [15:0] h_active,
    output logic [15:0] h_total,
    output logic [15:0] v_active,
    output logic [15:0] v_total,
    output logic        locked,
    output logic        error
);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        s_hs, s_vs, s_de, p_hs, p_vs, p_de;
    logic [15:0] hw, ht, va_cnt, vt_cnt, fh_act, fh_tot, fw, ft;
    logic [63:0] cand, ref_geo;
    logic        line_err, first_line, frame_seen;
    logic        hs_rise, vs_rise, de_rise, de_fall, first, w_err, t_err, close, bad, same;

    function automatic logic [15:0] inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        hs_rise = s_hs & ~p_hs;
        vs_rise = s_vs & ~p_vs;
        de_rise = s_de & ~p_de;
        de_fall = ~s_de & p_de;
        // A frame start in the same cycle as a DE rise belongs to the new frame.
        first   = first_line | vs_rise;
        fw      = vs_rise ? 16'd0 : fh_act;
        ft      = vs_rise ? 16'd0 : fh_tot;
        w_err   = de_fall && fw != 16'd0 && hw != fw;
        t_err   = de_rise && !first && ft != 16'd0 && ht != ft;
        close   = vs_rise & frame_seen;
        cand    = {fh_act, fh_tot, va_cnt, vt_cnt};
        bad     = line_err || va_cnt == 16'd0 || fh_act == 16'hFFFF || fh_tot == 16'hFFFF ||
                  va_cnt == 16'hFFFF || vt_cnt == 16'hFFFF;
        same    = cand == ref_geo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {s_hs, s_vs, s_de, p_hs, p_vs, p_de} <= '0;
            {hw, ht, va_cnt, vt_cnt, fh_act, fh_tot} <= '0;
            {line_err, first_line, frame_seen} <= '0;
            {pix_valid, xpos, ypos, frame_start} <= '0;
            {h_active, h_total, v_active, v_total} <= '0;
            {locked, error} <= '0;
            ref_geo <= '0;
            cnt     <= '0;
            state   <= UNLOCKED;
        end else begin
            s_hs       <= hsync == HSYNC_POL;
            s_vs       <= vsync == VSYNC_POL;
            s_de       <= data_en;
            p_hs       <= s_hs;
            p_vs       <= s_vs;
            p_de       <= s_de;
            hw         <= de_rise ? 16'd1 : s_de ? inc(hw) : hw;
            ht         <= de_rise ? 16'd1 : inc(ht);
            fh_act     <= (de_fall && fw == 16'd0) ? hw : fw;
            fh_tot     <= (de_rise && !first && ft == 16'd0) ? ht : ft;
            line_err   <= (line_err & ~vs_rise) | w_err | t_err;
            va_cnt     <= vs_rise ? {15'd0, de_rise} : de_rise ? inc(va_cnt) : va_cnt;
            vt_cnt     <= vs_rise ? {15'd0, hs_rise} : hs_rise ? inc(vt_cnt) : vt_cnt;
            first_line <= first & ~de_rise;
            frame_seen <= frame_seen | vs_rise;
            pix_valid  <= s_de;
            xpos       <= de_rise ? 16'd0 : s_de ? inc(xpos) : xpos;
            ypos       <= de_rise ? (first ? 16'd0 : inc(ypos)) : ypos;
            frame_start <= vs_rise;
            error      <= close && state == LOCKED && (bad || !same);
            if (close) begin
                {h_active, h_total, v_active, v_total} <= cand;
                unique case (state)
                    UNLOCKED: if (!bad) begin
                        ref_geo <= cand;
                        cnt     <= '0;
                        state   <= ACQUIRE;
                    end
                    ACQUIRE: if (bad) begin
                        state <= UNLOCKED;
                    end else if (same) begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 >= 8'(LOCK_FRAMES)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        ref_geo <= cand;
                        cnt     <= '0;
                    end
                    LOCKED: if (bad || !same) begin
                        state  <= UNLOCKED;
                        locked <= 1'b0;
                    end
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end
endmodule
